// File: rtl/seq_comparator.sv
// ---------------------------------------------------------------------------
// seq_comparator
//
// Compares two WIDTH-bit operands CHUNK bits at a time. It starts at the most
// significant chunk and stops at the first chunk that differs. Signed
// comparison is done by inverting the sign bit of both operands at capture.
// After that inversion an unsigned chunk compare gives the two's-complement
// ordering.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair offered
//   in_ready     high only while idle; accept = in_valid & in_ready
//   A, B         operands (WIDTH bits)
//   signed_mode  1: two's-complement compare, 0: unsigned (sampled at accept)
//   out_valid    result available (high only in DONE)
//   out_ready    consumer takes the result; out_valid & out_ready -> IDLE
//   gt, lt, eq   one-hot relation of A to B while out_valid, else all 0
//   cycles       number of chunks examined for the current/last result
// ---------------------------------------------------------------------------
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 A,
    input  logic [WIDTH-1:0]                 B,
    input  logic                             signed_mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             gt,
    output logic                             lt,
    output logic                             eq,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0] cycles
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int CW   = $clog2(NCH + 1);
    // A single-chunk configuration still needs a 1-bit index register.
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCH - 1);
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);
    localparam logic [CW-1:0]   CYC_ONE = CW'(1);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [IDXW-1:0]  idx_reg, idx_next;
    logic [CW-1:0]    cycles_reg, cycles_next;
    logic             gt_reg, gt_next;
    logic             lt_reg, lt_next;
    logic             eq_reg, eq_next;

    // Chunk views of the captured operands, indexed by chunk number.
    logic [CHUNK-1:0] a_chunk [NCH];
    logic [CHUNK-1:0] b_chunk [NCH];
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_sel = a_chunk[idx_reg];
    assign b_sel = b_chunk[idx_reg];

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        idx_next    = idx_reg;
        cycles_next = cycles_reg;
        gt_next     = gt_reg;
        lt_next     = lt_reg;
        eq_next     = eq_reg;

        case (state_reg)
            IDLE: begin
                // in_ready is implied by being in IDLE.
                if (in_valid) begin
                    // Flipping the sign bit maps two's-complement order onto
                    // unsigned order, so BUSY never needs to know the mode.
                    a_next      = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
                    b_next      = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
                    idx_next    = IDX_TOP;
                    cycles_next = '0;
                    state_next  = BUSY;
                end
            end

            BUSY: begin
                cycles_next = cycles_reg + CYC_ONE;
                if (a_sel != b_sel) begin
                    // First differing chunk decides the result.
                    gt_next    = (a_sel > b_sel);
                    lt_next    = (a_sel < b_sel);
                    state_next = DONE;
                end else if (idx_reg == '0) begin
                    eq_next    = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - IDX_ONE;
                end
            end

            DONE: begin
                // Flags clear at handoff so they read 0 whenever out_valid is 0.
                // cycles is deliberately left as it is.
                if (out_ready) begin
                    gt_next    = 1'b0;
                    lt_next    = 1'b0;
                    eq_next    = 1'b0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            idx_reg    <= '0;
            cycles_reg <= '0;
            gt_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            idx_reg    <= idx_next;
            cycles_reg <= cycles_next;
            gt_reg     <= gt_next;
            lt_reg     <= lt_next;
            eq_reg     <= eq_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign gt        = gt_reg;
    assign lt        = lt_reg;
    assign eq        = eq_reg;
    assign cycles    = cycles_reg;

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 2: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1: operand pair offered.
REQ-006 Port in_ready, output, 1: block can accept operands.
REQ-007 Port A, input, WIDTH: operand A.
REQ-008 Port B, input, WIDTH: operand B.
REQ-009 Port signed_mode, input, 1: 1 means two's-complement comparison; 0 means unsigned.
REQ-010 Port out_valid, output, 1: result available.
REQ-011 Port out_ready, input, 1: consumer accepts result.
REQ-012 Port gt, output, 1: A > B.
REQ-013 Port lt, output, 1: A < B.
REQ-014 Port eq, output, 1: A == B.
REQ-015 Port cycles, output, $clog2(NCH+1): number of chunks examined for the current result.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 out_valid SHALL be 1 only in DONE.
REQ-019 Accept SHALL occur on an edge where in_valid and in_ready are both 1.
- Capture A and B into internal registers.
- In signed mode, invert bit WIDTH-1 of both captured operands.
- Set chunk index to NCH-1, clear cycles, go to BUSY.
REQ-020 signed_mode SHALL be sampled only at accept; A, B and signed_mode changes after accept SHALL have no effect on the operation in progress.
REQ-021 In BUSY, each cycle SHALL compare captured chunk [idx*CHUNK +: CHUNK] of A against B, unsigned, MSB chunk first, and increment cycles.
REQ-022 On a chunk mismatch, the block SHALL register gt or lt per that chunk and go to DONE at the same edge (early termination).
REQ-023 On a match with idx==0, the block SHALL register eq=1 and go to DONE; on a match with idx>0, it SHALL decrement idx and stay in BUSY.
REQ-024 Latency: with accept at edge k, out_valid SHALL rise after edge k+m, where m is the number of chunks examined (1..NCH).
REQ-025 In DONE, gt, lt, eq and cycles SHALL hold stable until out_valid and out_ready are both 1; that edge returns the FSM to IDLE.
REQ-026 No new accept SHALL occur in the same cycle as result handoff; minimum issue interval is m+2 cycles.
REQ-027 Exactly one of gt/lt/eq SHALL be 1 while out_valid=1.
REQ-028 gt, lt and eq SHALL all be 0 while out_valid=0.
REQ-029 cycles SHALL retain its last value outside DONE.
REQ-030 in_valid asserted in BUSY or DONE SHALL be ignored, with no operand capture.

Reset
REQ-031 While rst_n=0, regardless of clk:
- FSM SHALL be IDLE.
- in_ready SHALL be 1.
- out_valid, gt, lt, eq SHALL be 0; cycles SHALL be 0.
- Internal operand registers SHALL be 0.
REQ-032 No accept SHALL occur while rst_n=0.
REQ-033 Reset asserted in BUSY or DONE SHALL abandon the operation with no result delivered; the first accept after rst_n rises SHALL behave as from power-up.

Verification
REQ-034 WIDTH=8, CHUNK=2, unsigned, A=0x5A, B=0x5A: eq=1, cycles=4, out_valid 4 edges after accept.
REQ-035 A=0x80, B=0x7F: with signed_mode=0, gt=1 and cycles=1; with signed_mode=1, lt=1 and cycles=1.
REQ-036 Unsigned A=0x12, B=0x13: lt=1, cycles=4; A=0xC0, B=0x40: gt=1, cycles=1.
REQ-037 Backpressure: out_ready=0 for 5 cycles after out_valid rises, with in_valid pulsed meanwhile:
- out_valid, gt/lt/eq and cycles held.
- in_ready=0.
- No capture.
- IDLE one edge after out_ready=1.
REQ-038 rst_n pulsed low mid-BUSY: outputs zero and in_ready=1 immediately, with no result emitted; a next operation with A=0x03, B=0x01 returns gt=1, cycles=4.
REQ-039 WIDTH=2, CHUNK=1: all 16 unsigned A/B pairs yield gt/lt/eq equal to the 2-bit magnitude relation, with cycles=1 when the MSBs differ and 2 otherwise.
